// File: rtl/risc16_pkg.sv
// risc16_pkg: shared widths, the NOP encoding and the fetch state type for RiSC-16.
package risc16_pkg;
    localparam int WORD_W = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts unanswered request cycles and flags the cycle in which
// the count would reach TIMEOUT-1.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    assign tc_o  = en_i && !clr_i && cnt_q == CW'(TIMEOUT - 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches the instruction at the current PC over a req/ack memory port
// and hands it to decode with valid/ready, driving the PC load enable.
module instr_fetch
    import risc16_pkg::*;
#(
    parameter int ADDR_W  = WORD_W,
    parameter int INSTR_W = WORD_W,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               flush,
    output logic               pc_load_en,
    output logic               fetch_err
);
    fetch_state_e       state_q;
    logic               req_q, valid_q, err_q, discard_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] instr_q;
    logic               issued, drop, tc;

    // REQ with req_q low is the one-cycle (re)capture slot that samples the settled PC
    assign issued = state_q == REQ && req_q;
    assign drop   = flush || discard_q;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!issued || imem_ack),
        .en_i  (issued && !imem_ack),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            instr_q   <= INSTR_W'(NOP_INSTR);
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_addr;
                end
                REQ: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= pc_addr;
                        if (flush) discard_q <= 1'b1;
                    end else if (imem_ack) begin
                        req_q     <= 1'b0;
                        discard_q <= 1'b0;
                        if (!drop) begin
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end else if (tc) begin
                        req_q     <= 1'b0;
                        instr_q   <= INSTR_W'(NOP_INSTR);
                        err_q     <= 1'b1;
                        discard_q <= 1'b0;
                        valid_q   <= !drop;
                        if (!drop) state_q <= HOLD;
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || (valid_q && instr_ready)) begin
                        valid_q <= 1'b0;
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign pc_load_en  = (state_q == HOLD && valid_q && instr_ready) || flush;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run against a PC/memory model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_addr, pc_init, flush_tgt, rdata_d, rdata_m;
    logic        ack_d, ack_m, instr_ready, flush, mem_auto;
    logic        imem_req, instr_valid, pc_load_en, fetch_err;
    logic [15:0] imem_addr, instr_out;
    int          n_chk = 0, n_pass = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_addr     (pc_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (mem_auto ? ack_m : ack_d),
        .imem_rdata  (mem_auto ? rdata_m : rdata_d),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .pc_load_en  (pc_load_en),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [15:0] word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // PC register and instruction memory environment
    initial begin : env
        logic lo, fl;
        int   wcnt, lat;
        wcnt = 0; lat = 0; ack_m = 1'b0; rdata_m = '0;
        forever begin
            @(negedge clk);
            lo = pc_load_en;
            fl = flush;
            @(posedge clk);
            #1;
            if (!rst_n) pc_addr = pc_init;
            else if (lo) pc_addr = fl ? flush_tgt : pc_addr + 16'd1;
            ack_m = 1'b0;
            if (imem_req && wcnt >= lat) begin
                ack_m = 1'b1; rdata_m = word(imem_addr); wcnt = 0; lat = $urandom_range(0, 3);
            end else if (imem_req) wcnt++;
            else wcnt = 0;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [15:0] a);
        pc_init = a;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ack_d = 0; rdata_d = '0; instr_ready = 0; flush = 0; mem_auto = 0; flush_tgt = '0;
        pc_init = 16'h0010;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if ({imem_req, instr_valid, pc_load_en, fetch_err} !== 4'b0000) $display("FAIL reset_flags got %b exp 0000", {imem_req, instr_valid, pc_load_en, fetch_err}); else n_pass++;
        n_chk++; if (imem_addr !== 16'h0000 || instr_out !== 16'h0000) $display("FAIL reset_data got addr %h instr %h exp 0000 0000", imem_addr, instr_out); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_chk++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b exp 0", imem_req); else n_pass++;
        nxt();
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) $display("FAIL first_req got %b/%h exp 1/0010", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_zero_wait();
        ack_d = 1; rdata_d = 16'hA5C3; instr_ready = 1;
        nxt();
        ack_d = 0;
        @(negedge clk);
        n_chk++; if (instr_valid !== 1'b1 || instr_out !== 16'hA5C3) $display("FAIL zw_valid got %b/%h exp 1/a5c3", instr_valid, instr_out); else n_pass++;
        n_chk++; if (pc_load_en !== 1'b1) $display("FAIL zw_load got %b exp 1", pc_load_en); else n_pass++;
        nxt();
        @(negedge clk);
        n_chk++; if ({pc_load_en, instr_valid, imem_req} !== 3'b000) $display("FAIL zw_gap got %b exp 000", {pc_load_en, instr_valid, imem_req}); else n_pass++;
        nxt();
        instr_ready = 0;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0011) $display("FAIL zw_next got %b/%h exp 1/0011", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_wait_backpressure();
        logic [15:0] r;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0011) $display("FAIL ws_hold%0d got %b/%h exp 1/0011", i, imem_req, imem_addr); else n_pass++;
            nxt();
            @(negedge clk);
        end
        r = 16'($urandom);
        ack_d = 1; rdata_d = r;
        nxt();
        ack_d = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++; if (instr_valid !== 1'b1 || instr_out !== r || pc_load_en !== 1'b0) $display("FAIL bp%0d got %b/%h/%b exp 1/%h/0", i, instr_valid, instr_out, pc_load_en, r); else n_pass++;
            nxt();
        end
        instr_ready = 1;
        @(negedge clk);
        n_chk++; if (pc_load_en !== 1'b1 || instr_out !== r) $display("FAIL bp_release got %b/%h exp 1/%h", pc_load_en, instr_out, r); else n_pass++;
        nxt();
        instr_ready = 0;
        @(negedge clk);
        n_chk++; if ({imem_req, instr_valid} !== 2'b00) $display("FAIL bp_gap got %b exp 00", {imem_req, instr_valid}); else n_pass++;
        nxt();
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0012) $display("FAIL bp_next got %b/%h exp 1/0012", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_flush_req();
        do_reset(16'h0020);
        nxt();
        flush = 1; flush_tgt = 16'h0040;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020 || pc_load_en !== 1'b1) $display("FAIL fl_c1 got %b/%h/%b exp 1/0020/1", imem_req, imem_addr, pc_load_en); else n_pass++;
        nxt();
        flush = 0;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) $display("FAIL fl_c2 got %b/%h exp 1/0020", imem_req, imem_addr); else n_pass++;
        nxt();
        ack_d = 1; rdata_d = 16'hBEEF;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) $display("FAIL fl_c3 got %b/%h exp 1/0020", imem_req, imem_addr); else n_pass++;
        nxt();
        ack_d = 0;
        @(negedge clk);
        n_chk++; if ({imem_req, instr_valid} !== 2'b00) $display("FAIL fl_drop got %b exp 00", {imem_req, instr_valid}); else n_pass++;
        nxt();
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_valid !== 1'b0) $display("FAIL fl_new got %b/%h/%b exp 1/0040/0", imem_req, imem_addr, instr_valid); else n_pass++;
        ack_d = 1; rdata_d = 16'h1234;
        nxt();
        ack_d = 0;
        @(negedge clk);
        n_chk++; if (instr_valid !== 1'b1 || instr_out !== 16'h1234) $display("FAIL fl_data got %b/%h exp 1/1234", instr_valid, instr_out); else n_pass++;
    endtask

    task automatic test_timeout();
        nxt();
        instr_ready = 1;
        @(negedge clk);
        n_chk++; if (pc_load_en !== 1'b1) $display("FAIL to_xfer got %b exp 1", pc_load_en); else n_pass++;
        nxt();
        instr_ready = 0;
        nxt();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_chk++; if ({imem_req, fetch_err} !== 2'b10 || imem_addr !== 16'h0041) $display("FAIL to_wait%0d got %b/%h exp 10/0041", i, {imem_req, fetch_err}, imem_addr); else n_pass++;
            nxt();
        end
        @(negedge clk);
        n_chk++; if ({imem_req, instr_valid, fetch_err} !== 3'b011 || instr_out !== 16'h0000) $display("FAIL to_abort got %b/%h exp 011/0000", {imem_req, instr_valid, fetch_err}, instr_out); else n_pass++;
        nxt();
        instr_ready = 1;
        @(negedge clk);
        n_chk++; if (pc_load_en !== 1'b1) $display("FAIL to_nop_xfer got %b exp 1", pc_load_en); else n_pass++;
        nxt();
        instr_ready = 0;
    endtask

    task automatic test_random();
        int xfers = 0;
        mem_auto = 1;
        for (int i = 0; i < 600; i++) begin
            nxt();
            instr_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            if (flush) flush_tgt = 16'($urandom);
            @(negedge clk);
            n_chk++; if (pc_load_en !== ((instr_valid && instr_ready) || flush)) $display("FAIL rnd_load%0d got %b v=%b r=%b f=%b", i, pc_load_en, instr_valid, instr_ready, flush); else n_pass++;
            if (instr_valid && instr_ready && !flush) begin
                xfers++;
                n_chk++; if (instr_out !== word(pc_addr)) $display("FAIL rnd_instr%0d pc %h got %h exp %h", i, pc_addr, instr_out, word(pc_addr)); else n_pass++;
            end
        end
        nxt();
        flush = 0;
        n_chk++; if (xfers < 40) $display("FAIL rnd_progress got %0d transfers exp >=40", xfers); else n_pass++;
        n_chk++; if (fetch_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", fetch_err); else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        int k = 0;
        mem_auto = 0; ack_d = 0; instr_ready = 1;
        while (imem_req !== 1'b1 && k < 20) begin
            nxt();
            k++;
        end
        instr_ready = 0;
        n_chk++; if (imem_req !== 1'b1) $display("FAIL mid_wait got %b exp 1 within 20 cycles", imem_req); else n_pass++;
        @(negedge clk);
        pc_init = 16'h0077;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({imem_req, instr_valid, fetch_err, pc_load_en} !== 4'b0000 || imem_addr !== 16'h0000 || instr_out !== 16'h0000) $display("FAIL mid_reset got %b/%h/%h exp 0000/0000/0000", {imem_req, instr_valid, fetch_err, pc_load_en}, imem_addr, instr_out); else n_pass++;
        ack_d = 1; rdata_d = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();
        @(negedge clk);
        n_chk++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0077) $display("FAIL mid_idle_ack got %b/%b/%h exp 0/1/0077", instr_valid, imem_req, imem_addr); else n_pass++;
        ack_d = 0;
        nxt();
        @(negedge clk);
        n_chk++; if (instr_valid !== 1'b0 || instr_out !== 16'h0000 || fetch_err !== 1'b0) $display("FAIL mid_after got %b/%h/%b exp 0/0000/0", instr_valid, instr_out, fetch_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_backpressure();
        test_flush_req();
        test_timeout();
        test_random();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
